// File: rtl/ft_rollback_ctrl.sv
//------------------------------------------------------------------------------
// +--------------------------------------------------------------------------+
// | Module      : ft_rollback_ctrl                                           |
// | Description : Checkpoint/rollback sequencer for the dual-core lockstep   |
// |               SoC. Periodically snapshots core_0 x1..x31 and the resume  |
// |               PC into a double-banked shadow store, and on a lockstep    |
// |               mismatch restores both cores from the committed bank.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
//------------------------------------------------------------------------------
`default_nettype none

module ft_rollback_ctrl #(
    parameter int          CKPT_INTERVAL = 64,
    parameter int          MAX_RETRY     = 3,
    parameter logic [31:0] BOOT_ADDR     = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        error_i,
    input  logic        commit_i,
    input  logic [31:0] resume_pc_i,
    input  logic        halted_i,
    input  logic [31:0] rf_rdata_i,
    output logic        halt_o,
    output logic [4:0]  rf_addr_o,
    output logic        rf_we_o,
    output logic [31:0] rf_wdata_o,
    output logic        pc_set_o,
    output logic [31:0] pc_o,
    output logic        fatal_o,
    output logic [15:0] rollback_cnt_o
);

    // Commit counter only needs to reach CKPT_INTERVAL-1.
    localparam int                    c_CCNT_W    = (CKPT_INTERVAL > 1) ? $clog2(CKPT_INTERVAL) : 1;
    localparam logic [c_CCNT_W-1:0]   c_CCNT_LAST = c_CCNT_W'(CKPT_INTERVAL - 1);
    // Retry counter must be able to hold MAX_RETRY+1 to flag the exhausted case.
    localparam int                    c_RETRY_W   = $clog2(MAX_RETRY + 2);
    localparam logic [c_RETRY_W-1:0]  c_RETRY_MAX = c_RETRY_W'(MAX_RETRY);
    localparam logic [c_RETRY_W-1:0]  c_RETRY_ONE = c_RETRY_W'(1);
    // Sweep index k runs 0..30, covering x1..x31.
    localparam logic [4:0]            c_LAST_K    = 5'd30;

    typedef enum logic [2:0] {
        S_RUN      = 3'd0,
        S_CK_HALT  = 3'd1,
        S_CK_COPY  = 3'd2,
        S_RB_HALT  = 3'd3,
        S_RB_WRITE = 3'd4,
        S_RB_JUMP  = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t                r_state;
    logic [c_CCNT_W-1:0]   r_ccnt;
    logic [c_RETRY_W-1:0]  r_retry;
    logic                  r_act;
    logic                  r_ck_valid;
    logic [4:0]            r_k;

    logic                  r_halt;
    logic [4:0]            r_rf_addr;
    logic                  r_rf_we;
    logic [31:0]           r_rf_wdata;
    logic                  r_pc_set;
    logic [31:0]           r_pc;
    logic                  r_fatal;
    logic [15:0]           r_rb_cnt;

    // Shadow store: two banks of x1..x31 plus a resume PC each. Not reset.
    logic [31:0]           r_bank    [0:1][0:30];
    logic [31:0]           r_bank_pc [0:1];

    logic                  w_enter_rb;
    logic                  w_ck_pc_we;
    logic                  w_ck_rf_we;
    logic                  w_inact;
    logic [4:0]            w_rd_k;
    logic [31:0]           w_restore_data;
    logic [31:0]           w_restore_pc;

    // A mismatch is only acted on while the cores are meant to be in lockstep;
    // during restore they diverge on purpose, so RB_WRITE/RB_JUMP ignore it.
    assign w_enter_rb = error_i && ((r_state == S_RUN) ||
                                    (r_state == S_CK_HALT) ||
                                    (r_state == S_CK_COPY));

    // Snapshots always land in the inactive bank; an abort simply never flips act.
    assign w_inact    = ~r_act;
    assign w_ck_pc_we = (r_state == S_CK_HALT) && halted_i && !error_i;
    assign w_ck_rf_we = (r_state == S_CK_COPY) && !error_i;

    // Restore data is registered one step ahead: fetch entry k+1 while k is on the bus.
    assign w_rd_k         = ((r_state == S_RB_WRITE) && (r_k != c_LAST_K)) ? (r_k + 5'd1) : 5'd0;
    assign w_restore_data = r_ck_valid ? r_bank[r_act][w_rd_k] : 32'd0;
    assign w_restore_pc   = r_ck_valid ? r_bank_pc[r_act] : BOOT_ADDR;

    assign halt_o         = r_halt;
    assign rf_addr_o      = r_rf_addr;
    assign rf_we_o        = r_rf_we;
    assign rf_wdata_o     = r_rf_wdata;
    assign pc_set_o       = r_pc_set;
    assign pc_o           = r_pc;
    assign fatal_o        = r_fatal;
    assign rollback_cnt_o = r_rb_cnt;

    // Capture the resume PC and the swept register values into the inactive bank.
    always_ff @(posedge clk_i) begin
        if (w_ck_pc_we) begin
            r_bank_pc[w_inact] <= resume_pc_i;
        end
        if (w_ck_rf_we) begin
            r_bank[w_inact][r_k] <= rf_rdata_i;
        end
    end

    // Sequencer with registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_RUN;
            r_ccnt     <= '0;
            r_retry    <= '0;
            r_act      <= 1'b0;
            r_ck_valid <= 1'b0;
            r_k        <= 5'd0;
            r_halt     <= 1'b0;
            r_rf_addr  <= 5'd0;
            r_rf_we    <= 1'b0;
            r_rf_wdata <= 32'd0;
            r_pc_set   <= 1'b0;
            r_pc       <= 32'd0;
            r_fatal    <= 1'b0;
            r_rb_cnt   <= 16'd0;
        end else if (w_enter_rb) begin
            // Error wins over a simultaneous checkpoint trigger and aborts any
            // checkpoint in flight.
            r_state    <= S_RB_HALT;
            r_halt     <= 1'b1;
            r_rf_addr  <= 5'd0;
            r_rf_we    <= 1'b0;
            r_rf_wdata <= 32'd0;
            r_pc_set   <= 1'b0;
            r_k        <= 5'd0;
            if (r_rb_cnt != 16'hFFFF) begin
                r_rb_cnt <= r_rb_cnt + 16'd1;
            end
            if (r_retry <= c_RETRY_MAX) begin
                r_retry <= r_retry + c_RETRY_ONE;
            end
        end else begin
            case (r_state)
                S_RUN: begin
                    if (commit_i) begin
                        if (r_ccnt == c_CCNT_LAST) begin
                            r_ccnt  <= '0;
                            r_state <= S_CK_HALT;
                            r_halt  <= 1'b1;
                        end else begin
                            r_ccnt <= r_ccnt + c_CCNT_W'(1);
                        end
                    end
                end

                S_CK_HALT: begin
                    if (halted_i) begin
                        r_state   <= S_CK_COPY;
                        r_k       <= 5'd0;
                        r_rf_addr <= 5'd1;
                    end
                end

                S_CK_COPY: begin
                    if (r_k == c_LAST_K) begin
                        r_act      <= ~r_act;
                        r_ck_valid <= 1'b1;
                        r_retry    <= '0;
                        r_state    <= S_RUN;
                        r_halt     <= 1'b0;
                        r_rf_addr  <= 5'd0;
                        r_k        <= 5'd0;
                    end else begin
                        r_k       <= r_k + 5'd1;
                        r_rf_addr <= r_k + 5'd2;
                    end
                end

                S_RB_HALT: begin
                    // Retry was already at the limit when this rollback started.
                    if (r_retry > c_RETRY_MAX) begin
                        r_state <= S_FAIL;
                        r_fatal <= 1'b1;
                    end else if (halted_i) begin
                        r_state    <= S_RB_WRITE;
                        r_k        <= 5'd0;
                        r_rf_we    <= 1'b1;
                        r_rf_addr  <= 5'd1;
                        r_rf_wdata <= w_restore_data;
                    end
                end

                S_RB_WRITE: begin
                    if (r_k == c_LAST_K) begin
                        r_state    <= S_RB_JUMP;
                        r_k        <= 5'd0;
                        r_rf_we    <= 1'b0;
                        r_rf_addr  <= 5'd0;
                        r_rf_wdata <= 32'd0;
                        r_pc_set   <= 1'b1;
                        r_pc       <= w_restore_pc;
                    end else begin
                        r_k        <= r_k + 5'd1;
                        r_rf_addr  <= r_k + 5'd2;
                        r_rf_wdata <= w_restore_data;
                    end
                end

                S_RB_JUMP: begin
                    r_state  <= S_RUN;
                    r_halt   <= 1'b0;
                    r_pc_set <= 1'b0;
                    r_ccnt   <= '0;
                end

                S_FAIL: begin
                    r_halt     <= 1'b1;
                    r_fatal    <= 1'b1;
                    r_rf_we    <= 1'b0;
                    r_rf_addr  <= 5'd0;
                    r_rf_wdata <= 32'd0;
                    r_pc_set   <= 1'b0;
                end

                default: begin
                    r_state <= S_RUN;
                    r_halt  <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/ft_rollback_ctrl.md
# ft_rollback_ctrl

Checkpoint/rollback sequencer for the dual-core lockstep SoC. It counts retired instructions and periodically halts both cores to snapshot the core_0 register file (x1..x31) and the resume PC into a double-banked shadow store. When the lockstep comparator flags a mismatch, it halts both cores, rewrites both register files from the last committed checkpoint and redirects both PCs. It sits beside the fault-tolerance module, between the comparator error line and the cores' halt, register-file and PC-override ports.

## Interface
- CKPT_INTERVAL, 64: retired instructions between checkpoints (≥1).
- MAX_RETRY, 3: rollbacks allowed without an intervening completed checkpoint.
- BOOT_ADDR, 32'h0000_0080: resume PC when no checkpoint exists.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- error_i  in  1  lockstep mismatch, level, from the comparator.
- commit_i  in  1  one-cycle pulse per retired instruction (core_0).
- resume_pc_i  in  32  address of the next instruction to retire.
- halted_i  in  1  both cores stalled and quiescent (AND of the acks).
- rf_rdata_i  in  32  core_0 register-file read data (combinational on rf_addr_o).
- halt_o  out  1  stall request to both cores.
- rf_addr_o  out  5  register-file address, shared by read and write.
- rf_we_o  out  1  write enable, broadcast to both cores.
- rf_wdata_o  out  32  write data, broadcast to both cores.
- pc_set_o  out  1  one-cycle PC override strobe to both cores.
- pc_o  out  32  override PC.
- fatal_o  out  1  unrecoverable; sticky until reset.
- rollback_cnt_o  out  16  rollbacks performed; saturates at 16'hFFFF.

## Operation
- States: RUN, CK_HALT, CK_COPY, RB_HALT, RB_WRITE, RB_JUMP, FAIL.
- Outputs decode from the state register. There are no combinational paths from inputs to outputs.
- Shadow store: two banks, each 31×32 data plus a 32-bit PC. The `act` pointer selects the committed bank. `ck_valid` starts at 0.
- RUN: commit_i increments `ccnt`.
  - commit_i while `ccnt == CKPT_INTERVAL-1` → CK_HALT and `ccnt` clears.
  - error_i → RB_HALT. Error takes priority over a simultaneous checkpoint trigger.
- CK_HALT: halt_o=1. Wait for halted_i, then latch resume_pc_i into the inactive bank and go to CK_COPY.
- CK_COPY: index k=0..30, one per cycle.
  - rf_addr_o=k+1. rf_rdata_i is written into inactive-bank entry k at the clock edge.
  - After k=30: toggle `act`, set `ck_valid`=1, clear `retry`, go to RUN.
- error_i in CK_HALT or CK_COPY aborts the checkpoint → RB_HALT. The inactive bank is discarded and `act` does not change.
- RB_HALT: halt_o=1.
  - On entry: increment rollback_cnt_o (saturating) and `retry`.
  - If `retry` was already MAX_RETRY on entry → FAIL.
  - Otherwise wait for halted_i, then go to RB_WRITE.
- RB_WRITE: k=0..30, one per cycle. rf_we_o=1, rf_addr_o=k+1, rf_wdata_o = active-bank entry k, or 0 when `ck_valid`=0.
- RB_JUMP: one cycle. pc_set_o=1, halt_o=1, pc_o = active-bank PC, or BOOT_ADDR when `ck_valid`=0. `ccnt` clears. Next state RUN.
- error_i is ignored in RB_WRITE and RB_JUMP, because the cores are intentionally divergent during restore.
- FAIL: halt_o=1 and fatal_o=1 permanently. All other strobes are 0. Only reset exits.
- x0 is never read or written.

## Timing
- Reset values:
  - state=RUN, halt_o=0, rf_we_o=0, rf_addr_o=0, rf_wdata_o=0.
  - pc_set_o=0, pc_o=0, fatal_o=0, rollback_cnt_o=0.
  - `ccnt`, `retry`, `act`, `ck_valid` all 0.
  - Shadow banks are not reset.
- halt_o rises one cycle after the triggering commit or error edge.
- Checkpoint with halted_i already high: 1 (CK_HALT) + 31 (CK_COPY) cycles. halt_o falls in the cycle after k=30.
- Rollback with halted_i already high: 1 (RB_HALT) + 31 (RB_WRITE) + 1 (RB_JUMP) = 33 cycles. halt_o is low in the cycle after RB_JUMP.
- halted_i may take any number of cycles. There is no timeout.
- halted_i is sampled only in CK_HALT and RB_HALT. It must stay high until halt_o drops. The block does not recheck it.
- Reset mid-sequence returns immediately to reset values. Any partial writes already made to the register files stay in place.

## Test plan
- CKPT_INTERVAL=4, four commit_i pulses, halted_i tied high → CK_COPY sweeps rf_addr_o 1..31 over 31 cycles, then RUN. A later rollback restores the sampled values and pc_o = resume_pc_i captured at CK_HALT exit.
- error_i before any checkpoint → RB_WRITE writes 0 to x1..x31, then pc_set_o=1 with pc_o=32'h0000_0080. rollback_cnt_o=1.
- error_i raised at CK_COPY k=10 → abort. The rollback uses the previous bank's data and PC, with no partially copied values.
- error_i in the same cycle as the commit that reaches the interval → RB_HALT is entered and no checkpoint occurs.
- MAX_RETRY=3, four rollbacks with no completed checkpoint → on the fourth error fatal_o=1, halt_o held high, rf_we_o never asserted. rollback_cnt_o=4.
- halted_i delayed 7 cycles in RB_HALT, then reset asserted mid-RB_WRITE → no writes before halted_i, and all outputs return to reset values asynchronously.
